// File: rtl/bloom_filter_csr_stat_if.sv
// rtl/bloom_filter_csr_stat_if.sv - Avalon-MM CSR slave bus for the bloom filter CSR block.
interface bloom_filter_csr_stat_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              write;
  logic [DATA_W-1:0] writedata;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/bloom_filter_csr_stat.sv
// rtl/bloom_filter_csr_stat.sv - bloom filter CSRs, clear-on-read match counters, hash-LUT clean sequencer.
// Optional clean watchdog: BLOOM_FILTER_CSR_CLEAN_TIMEOUT_EN.
module bloom_filter_csr_stat #(
  parameter int AMM_CSR_ADDR_W = 4,
  parameter int AMM_CSR_DATA_W = 32,
  parameter int CHANNEL_CNT    = 4,
  parameter int CNT_W          = 32,
  parameter int CLEAN_TIMEOUT  = 1024
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  bloom_filter_csr_stat_if.slave amm_slave_csr,
  input  logic [CHANNEL_CNT-1:0] match_stb_i,
  output logic [CHANNEL_CNT-1:0] en_o,
  output logic                   hash_lut_clean_stb_o,
  input  logic                   hash_lut_clean_done_i,
  output logic                   irq_o
);
  localparam logic [AMM_CSR_ADDR_W-1:0] A_CTRL   = AMM_CSR_ADDR_W'(0);
  localparam logic [AMM_CSR_ADDR_W-1:0] A_CLEAN  = AMM_CSR_ADDR_W'(1);
  localparam logic [AMM_CSR_ADDR_W-1:0] A_STATUS = AMM_CSR_ADDR_W'(2);
  localparam logic [AMM_CSR_ADDR_W-1:0] A_MASK   = AMM_CSR_ADDR_W'(3);
  localparam logic [CNT_W-1:0]          CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
  state_t state, state_nxt;

  logic [CHANNEL_CNT-1:0]    ctrl_q, mask_q, status_q, sat_evt;
  logic [CNT_W-1:0]          cnt_q   [CHANNEL_CNT];
  logic [CNT_W-1:0]          cnt_nxt [CHANNEL_CNT];
  logic                      done_q, timeout_bit, to_expire;
  logic [AMM_CSR_DATA_W-1:0] rd_mux, wdata;
  logic                      wr_clean, clean_start;

  assign wdata       = amm_slave_csr.writedata;
  assign wr_clean    = amm_slave_csr.write && (amm_slave_csr.address == A_CLEAN);
  assign clean_start = wr_clean && wdata[0] && (state == ST_IDLE);
  assign en_o        = (state == ST_IDLE) ? ctrl_q : '0;

`ifdef BLOOM_FILTER_CSR_CLEAN_TIMEOUT_EN
  localparam int TO_W = $clog2(CLEAN_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  assign to_expire   = (state == ST_WAIT) && (to_cnt == TO_W'(CLEAN_TIMEOUT - 1));
  assign timeout_bit = timeout_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || state != ST_WAIT) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  // An arriving done takes precedence over a simultaneous expiry.
  always_ff @(posedge clk_i) begin
    if (srst_i || clean_start)                         timeout_q <= 1'b0;
    else if (to_expire && !hash_lut_clean_done_i)      timeout_q <= 1'b1;
    else if (wr_clean && wdata[2])                     timeout_q <= 1'b0;
  end
`else
  assign to_expire   = 1'b0;
  assign timeout_bit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    hash_lut_clean_stb_o = 1'b0;
    case (state)
      ST_IDLE: if (clean_start) state_nxt = ST_REQ;
      ST_REQ: begin
        hash_lut_clean_stb_o = 1'b1;
        state_nxt            = ST_WAIT;
      end
      ST_WAIT: if (hash_lut_clean_done_i || to_expire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || clean_start)                            done_q <= 1'b0;
    else if (state == ST_WAIT && hash_lut_clean_done_i)   done_q <= 1'b1;
    else if (wr_clean && wdata[1])                        done_q <= 1'b0;
  end

  // A read clears the counter, but a match counted in that same cycle survives as 1.
  always_comb begin
    for (int i = 0; i < CHANNEL_CNT; i++) begin
      cnt_nxt[i] = cnt_q[i];
      sat_evt[i] = 1'b0;
      if (amm_slave_csr.read && amm_slave_csr.address == AMM_CSR_ADDR_W'(4 + i)) begin
        cnt_nxt[i] = CNT_W'(match_stb_i[i] & en_o[i]);
        sat_evt[i] = match_stb_i[i] && en_o[i] && (CNT_MAX == CNT_W'(1));
      end else if (match_stb_i[i] && en_o[i] && cnt_q[i] != CNT_MAX) begin
        cnt_nxt[i] = cnt_q[i] + 1'b1;
        sat_evt[i] = (cnt_q[i] == CNT_MAX - 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < CHANNEL_CNT; i++) begin
      if (srst_i) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_nxt[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ctrl_q   <= '0;
      mask_q   <= '0;
      status_q <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (amm_slave_csr.write && amm_slave_csr.address == A_CTRL) ctrl_q <= wdata[CHANNEL_CNT-1:0];
      if (amm_slave_csr.write && amm_slave_csr.address == A_MASK) mask_q <= wdata[CHANNEL_CNT-1:0];
      if (amm_slave_csr.write && amm_slave_csr.address == A_STATUS)
        status_q <= (status_q & ~wdata[CHANNEL_CNT-1:0]) | sat_evt;
      else
        status_q <= status_q | sat_evt;
      irq_o <= |(status_q & mask_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (amm_slave_csr.address)
      A_CTRL:   rd_mux[CHANNEL_CNT-1:0] = ctrl_q;
      A_CLEAN:  rd_mux[2:0] = {timeout_bit, done_q, state != ST_IDLE};
      A_STATUS: rd_mux[CHANNEL_CNT-1:0] = status_q;
      A_MASK:   rd_mux[CHANNEL_CNT-1:0] = mask_q;
      default: begin
        for (int i = 0; i < CHANNEL_CNT; i++)
          if (amm_slave_csr.address == AMM_CSR_ADDR_W'(4 + i))
            rd_mux = AMM_CSR_DATA_W'(cnt_q[i]);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      amm_slave_csr.readdata      <= '0;
      amm_slave_csr.readdatavalid <= 1'b0;
    end else begin
      amm_slave_csr.readdatavalid <= amm_slave_csr.read;
      if (amm_slave_csr.read) amm_slave_csr.readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_bloom_filter_csr_stat.sv
// tb/tb_bloom_filter_csr_stat.sv - self-checking bench for bloom_filter_csr_stat.
module tb_bloom_filter_csr_stat;
  localparam int AW = 4, DW = 32, CH = 4, CW = 4, TO = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0, srst = 1'b1, done_i = 1'b0;
  logic [CH-1:0] match = '0, en;
  logic          stb, irq;
  int            checks = 0, errors = 0;

  bloom_filter_csr_stat_if #(.ADDR_W(AW), .DATA_W(DW)) csr_if ();

  bloom_filter_csr_stat #(
    .AMM_CSR_ADDR_W(AW), .AMM_CSR_DATA_W(DW), .CHANNEL_CNT(CH), .CNT_W(CW), .CLEAN_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .srst_i(srst), .amm_slave_csr(csr_if.slave), .match_stb_i(match),
    .en_o(en), .hash_lut_clean_stb_o(stb), .hash_lut_clean_done_i(done_i), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file, counters as integers, clean phase as idle/req/wait.
  logic [CH-1:0] m_ctrl, m_mask, m_status;
  int            m_cnt [CH];
  int            m_phase, m_age;
  bit            m_done, m_to, m_rv, m_irq, m_live = 1'b0, m_sat, m_hit, m_start;
  logic [31:0]   m_rd, m_wd;
  logic [CH-1:0] m_en_now;
  int            m_a;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'(m_ctrl);
    if (a == 1) return {29'b0, m_to, m_done, m_phase != 0};
    if (a == 2) return 32'(m_status);
    if (a == 3) return 32'(m_mask);
    if (a >= 4 && a < 4 + CH) return 32'(m_cnt[a-4]);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (srst) begin
      m_ctrl = '0; m_mask = '0; m_status = '0; m_phase = 0; m_age = 0;
      m_done = 0; m_to = 0; m_rv = 0; m_irq = 0; m_rd = '0; m_live = 1'b1;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else if (m_live) begin
      m_a      = int'(csr_if.address);
      m_wd     = csr_if.writedata;
      m_en_now = (m_phase == 0) ? m_ctrl : '0;
      m_irq    = |(m_status & m_mask);
      m_rv     = csr_if.read;
      if (csr_if.read) m_rd = model_read(m_a);
      for (int i = 0; i < CH; i++) begin
        m_hit = match[i] && m_en_now[i];
        m_sat = 0;
        if (csr_if.read && m_a == 4 + i) begin
          m_cnt[i] = m_hit ? 1 : 0;
          m_sat = m_hit && (MAXC == 1);
        end else if (m_hit && m_cnt[i] < MAXC) begin
          m_cnt[i]++;
          m_sat = (m_cnt[i] == MAXC);
        end
        if (csr_if.write && m_a == 2 && m_wd[i]) m_status[i] = 1'b0;
        if (m_sat) m_status[i] = 1'b1;
      end
      if (csr_if.write && m_a == 0) m_ctrl = m_wd[CH-1:0];
      if (csr_if.write && m_a == 3) m_mask = m_wd[CH-1:0];
      m_start = csr_if.write && m_a == 1 && m_wd[0] && m_phase == 0;
      if (csr_if.write && m_a == 1 && m_wd[1]) m_done = 0;
`ifdef BLOOM_FILTER_CSR_CLEAN_TIMEOUT_EN
      if (csr_if.write && m_a == 1 && m_wd[2]) m_to = 0;
`endif
      if (m_phase == 1) begin
        m_phase = 2; m_age = 0;
      end else if (m_phase == 2) begin
        if (done_i) begin
          m_phase = 0; m_done = 1;
        end else begin
          m_age++;
`ifdef BLOOM_FILTER_CSR_CLEAN_TIMEOUT_EN
          if (m_age == TO) begin m_phase = 0; m_to = 1; end
`endif
        end
      end else if (m_start) begin
        m_phase = 1; m_done = 0; m_to = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_live) begin
      check("en_o", 32'(en), 32'((m_phase == 0) ? m_ctrl : '0));
      check("clean_stb", 32'(stb), 32'(m_phase == 1));
      check("irq_o", 32'(irq), 32'(m_irq));
      check("rdvalid", 32'(csr_if.readdatavalid), 32'(m_rv));
      check("readdata", csr_if.readdata, m_rd);
    end
  end

  task automatic bus(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [CH-1:0] m);
    @(negedge clk);
    csr_if.read = rd; csr_if.write = wr; csr_if.address = a; csr_if.writedata = d; match = m;
    @(negedge clk);
    csr_if.read = 1'b0; csr_if.write = 1'b0; csr_if.address = '0; csr_if.writedata = '0; match = '0;
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
    bus(1'b1, 1'b0, a, 32'h0, '0);
    check({name, "_valid"}, 32'(csr_if.readdatavalid), 32'h1);
    check(name, csr_if.readdata, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d, '0);
  endtask

  task automatic done_pulse();
    @(negedge clk); done_i = 1'b1;
    @(negedge clk); done_i = 1'b0;
  endtask

  initial begin
    csr_if.read = 1'b0; csr_if.write = 1'b0; csr_if.address = '0; csr_if.writedata = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    check("rst_en", 32'(en), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 4 + CH; a++) rd_chk(AW'(a), 32'h0, "rst_read");
    rd_chk(4'd9, 32'h0, "unmapped");
    wr(4'd9, 32'hFFFF_FFFF);
    rd_chk(4'd9, 32'h0, "unmapped_wr");

    wr(4'd0, 32'h5);
    check("en_ctrl5", 32'(en), 32'h5);
    repeat (3) bus(1'b0, 1'b0, 4'd0, 32'h0, 4'hF);
    rd_chk(4'd4, 32'd3, "cnt0");
    rd_chk(4'd5, 32'd0, "cnt1");
    rd_chk(4'd6, 32'd3, "cnt2");
    rd_chk(4'd7, 32'd0, "cnt3");
    rd_chk(4'd4, 32'd0, "cnt0_cleared");

    repeat (7) bus(1'b0, 1'b0, 4'd0, 32'h0, 4'h1);
    bus(1'b1, 1'b0, 4'd4, 32'h0, 4'h1);
    check("cnt0_rd_with_match", csr_if.readdata, 32'd7);
    rd_chk(4'd4, 32'd1, "cnt0_after_collide");
    bus(1'b1, 1'b1, 4'd0, 32'h3, '0);
    check("rw_same_addr", csr_if.readdata, 32'h5);
    rd_chk(4'd0, 32'h3, "ctrl_after_rw");

    wr(4'd3, 32'h1);
    wr(4'd0, 32'h1);
    repeat (16) bus(1'b0, 1'b0, 4'd0, 32'h0, 4'h1);
    rd_chk(4'd4, 32'd15, "cnt0_sat");
    rd_chk(4'd2, 32'h1, "irq_status");
    check("irq_set", 32'(irq), 32'h1);
    wr(4'd2, 32'h1);
    check("irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);

    wr(4'd0, 32'hF);
    wr(4'd1, 32'h1);
    check("clean_stb_req", 32'(stb), 32'h1);
    check("clean_en_req", 32'(en), 32'h0);
    @(negedge clk);
    check("clean_stb_wait", 32'(stb), 32'h0);
    wr(4'd1, 32'h1);
    check("no_second_stb", 32'(stb), 32'h0);
    rd_chk(4'd1, 32'h1, "busy");
    done_pulse();
    check("en_after_done", 32'(en), 32'hF);
    rd_chk(4'd1, 32'h2, "done");
    wr(4'd1, 32'h2);
    rd_chk(4'd1, 32'h0, "done_w1c");

    wr(4'd1, 32'h1);
    repeat (12) @(negedge clk);
`ifdef BLOOM_FILTER_CSR_CLEAN_TIMEOUT_EN
    rd_chk(4'd1, 32'h4, "timeout");
    check("en_after_timeout", 32'(en), 32'hF);
`else
    rd_chk(4'd1, 32'h1, "wait_persists");
    done_pulse();
    rd_chk(4'd1, 32'h2, "late_done");
`endif

    wr(4'd1, 32'h1);
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_wait_stb", 32'(stb), 32'h0);
      @(negedge clk);
    end
    rd_chk(4'd1, 32'h0, "rst_wait_busy");
    check("rst_wait_en", 32'(en), 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
